// File: rtl/led_scan_controller.sv
// led_scan_controller: four-digit 7-segment multiplex scheduler.
// Cycles AN3->AN2->AN1->AN0 with a blanking interval at the start of each
// slot. A 16-bit display word is taken in through a valid/ready handshake
// and copied to the displayed word only at frame boundaries or while idle.
// Optional build macro: LEAD_ZERO_BLANK_EN (blank leading zero digits).
`timescale 1ns/1ps

module led_scan_controller #(
    parameter int PERIOD = 16,
    parameter int DEAD   = 2,
    parameter int CNT_W  = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    input  logic        load_valid,
    input  logic [15:0] load_data,
    output logic        load_ready,
    output logic        AN3,
    output logic        AN2,
    output logic        AN1,
    output logic        AN0,
    output logic [3:0]  digit,
    output logic        frame_tick
);

    typedef enum logic [1:0] {
        SLOT_AN3 = 2'd0,
        SLOT_AN2 = 2'd1,
        SLOT_AN1 = 2'd2,
        SLOT_AN0 = 2'd3
    } slot_t;

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(PERIOD - 1);
    localparam logic [CNT_W-1:0] DEAD_CNT = CNT_W'(DEAD);

    slot_t            slot_reg, slot_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [15:0]      active_reg;
    logic [15:0]      shadow_reg;
    logic             pending_reg;

    logic             transfer;
    logic             accept;
    logic [3:0]       nib [4];
    logic [3:0]       blank;
    logic [3:0]       an_low;

    // Slot/counter state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            slot_reg <= SLOT_AN3;
            cnt_reg  <= '0;
        end else begin
            slot_reg <= slot_next;
            cnt_reg  <= cnt_next;
        end
    end

    // Next slot/count: count while enabled, park at AN3/0 while disabled
    always_comb begin
        slot_next = slot_reg;
        cnt_next  = cnt_reg;
        if (!en) begin
            slot_next = SLOT_AN3;
            cnt_next  = '0;
        end else if (cnt_reg == LAST_CNT) begin
            cnt_next = '0;
            case (slot_reg)
                SLOT_AN3: slot_next = SLOT_AN2;
                SLOT_AN2: slot_next = SLOT_AN1;
                SLOT_AN1: slot_next = SLOT_AN0;
                default:  slot_next = SLOT_AN3;
            endcase
        end else begin
            cnt_next = cnt_reg + 1'b1;
        end
    end

    assign frame_tick = en && (slot_reg == SLOT_AN0) && (cnt_reg == LAST_CNT);
    assign load_ready = !pending_reg;
    // A transfer empties the shadow; ready only rises afterwards, so an
    // accept can never land on the same edge as a transfer.
    assign transfer   = pending_reg && (frame_tick || !en);
    assign accept     = load_valid && !pending_reg;

    // Shadow/active double buffer and handshake
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            active_reg  <= '0;
            shadow_reg  <= '0;
            pending_reg <= 1'b0;
        end else if (transfer) begin
            active_reg  <= shadow_reg;
            pending_reg <= 1'b0;
        end else if (accept) begin
            shadow_reg  <= load_data;
            pending_reg <= 1'b1;
        end
    end

    // Per-slot nibble, blanking and anode decode; index 0 is AN3
    for (genvar gi = 0; gi < 4; gi++) begin : g_slot
        assign nib[gi]    = active_reg[15-4*gi -: 4];
        assign an_low[gi] = en && (slot_reg == slot_t'(gi)) &&
                            (cnt_reg >= DEAD_CNT) && !blank[gi];
    end

`ifdef LEAD_ZERO_BLANK_EN
    // lead_zero[i]: this nibble and every higher nibble are zero
    logic [3:0] lead_zero;
    for (genvar gi = 0; gi < 4; gi++) begin : g_lz
        if (gi == 0) begin : g_first
            assign lead_zero[gi] = (nib[gi] == 4'd0);
        end else begin : g_rest
            assign lead_zero[gi] = lead_zero[gi-1] && (nib[gi] == 4'd0);
        end
    end
    // The units digit is always shown
    assign blank = {1'b0, lead_zero[2:0]};
`else
    assign blank = 4'b0000;
`endif

    assign digit = nib[slot_reg];
    assign AN3   = !an_low[0];
    assign AN2   = !an_low[1];
    assign AN1   = !an_low[2];
    assign AN0   = !an_low[3];

endmodule

// File: tb/tb_led_scan_controller.sv
// Randomized bench for led_scan_controller (PERIOD=8, DEAD=2) against a
// frame-position reference model.
`timescale 1ns/1ps

module tb_led_scan_controller;

    localparam int P     = 8;
    localparam int D     = 2;
    localparam int FRAME = 4 * P;
    localparam int NCYC  = 4000;

    logic        clk = 1'b0;
    logic        reset;
    logic        en;
    logic        load_valid;
    logic [15:0] load_data;
    logic        load_ready;
    logic        AN3, AN2, AN1, AN0;
    logic [3:0]  digit;
    logic        frame_tick;

    int errors = 0;
    int checks = 0;

    // Reference model: position inside the frame plus the two buffers
    int          m_pos;
    logic [15:0] m_active;
    logic [15:0] m_shadow;
    bit          m_pend;

    led_scan_controller #(.PERIOD(P), .DEAD(D), .CNT_W(16)) dut (
        .clk        (clk),
        .reset      (reset),
        .en         (en),
        .load_valid (load_valid),
        .load_data  (load_data),
        .load_ready (load_ready),
        .AN3        (AN3),
        .AN2        (AN2),
        .AN1        (AN1),
        .AN0        (AN0),
        .digit      (digit),
        .frame_tick (frame_tick)
    );

    always #5 clk = ~clk;

    task automatic check_value(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pos    = 0;
        m_active = 16'h0000;
        m_shadow = 16'h0000;
        m_pend   = 1'b0;
    endtask

    function automatic bit model_tick();
        return en && (m_pos == FRAME - 1);
    endfunction

    // Compare every output against the model for the current cycle
    task automatic compare_outputs();
        int          slot;
        int          c;
        bit          blank;
        logic [3:0]  exp_an;
        logic [3:0]  an;
        logic [15:0] sh;
        int          lows;
        slot  = m_pos / P;
        c     = m_pos % P;
        blank = 1'b0;
`ifdef LEAD_ZERO_BLANK_EN
        blank = (slot < 3) && ((m_active >> (12 - 4 * slot)) == 16'h0000);
`endif
        exp_an = 4'b1111;
        if (en && c >= D && !blank) exp_an[3 - slot] = 1'b0;
        an = {AN3, AN2, AN1, AN0};
        sh = m_active >> (4 * (3 - slot));
        check_value("anodes", {12'h0, an}, {12'h0, exp_an});
        check_value("digit", {12'h0, digit}, {12'h0, sh[3:0]});
        check_value("load_ready", {15'h0, load_ready}, {15'h0, !m_pend});
        check_value("frame_tick", {15'h0, frame_tick}, {15'h0, model_tick()});
        lows = 0;
        for (int i = 0; i < 4; i++) if (an[i] == 1'b0) lows++;
        check_value("an_at_most_one", {15'h0, (lows <= 1)}, 16'h0001);
        check_value("an_dead_dark", {15'h0, (c < D && an != 4'b1111)}, 16'h0000);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_value({tag, "_an"}, {12'h0, AN3, AN2, AN1, AN0}, 16'h000F);
        check_value({tag, "_digit"}, {12'h0, digit}, 16'h0000);
        check_value({tag, "_ready"}, {15'h0, load_ready}, 16'h0001);
        check_value({tag, "_tick"}, {15'h0, frame_tick}, 16'h0000);
    endtask

    // Advance the model across one rising edge using the applied inputs
    task automatic model_step(input int cyc);
        bit tick;
        tick = model_tick();
        if (m_pend && (tick || !en)) begin
            m_active = m_shadow;
            m_pend   = 1'b0;
            $display("cyc=%0d transfer active=%h", cyc, m_active);
        end else if (load_valid && !m_pend) begin
            m_shadow = load_data;
            m_pend   = 1'b1;
            $display("cyc=%0d load accepted data=%h", cyc, load_data);
        end
        if (en) m_pos = (m_pos + 1) % FRAME;
        else    m_pos = 0;
    endtask

    initial begin
        int          en_hold;
        bit          second_done;
        logic [31:0] rnd;

        reset      = 1'b1;
        en         = 1'b0;
        load_valid = 1'b0;
        load_data  = 16'h0000;
        en_hold    = 0;
        second_done = 1'b0;
        model_reset();

        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset_state");
        @(posedge clk);
        #1 reset = 1'b0;

        for (int cyc = 0; cyc < NCYC; cyc++) begin
            if (cyc < 100) begin
                // Directed opening: first word, then a second held off until transfer
                en         = 1'b1;
                load_valid = (cyc == 10) || (cyc >= 12 && !second_done);
                load_data  = (cyc == 10) ? 16'h1234 : 16'h0050;
            end else begin
                if (en_hold == 0) begin
                    en      = ($urandom_range(0, 4) != 0);
                    en_hold = en ? $urandom_range(10, 90) : $urandom_range(1, 6);
                end
                en_hold--;
                rnd        = $urandom;
                load_valid = ($urandom_range(0, 3) == 0);
                load_data  = rnd[15:0] >> (4 * $urandom_range(0, 4));
            end

            @(negedge clk);
            compare_outputs();

            if (cyc % 900 == 450) begin
                // Asynchronous reset in the middle of a cycle, pending word dropped
                #1 reset = 1'b1;
                #1 check_reset_outputs("async_reset");
                model_reset();
                $display("cyc=%0d async reset", cyc);
                @(posedge clk);
                #1 reset = 1'b0;
                continue;
            end

            @(posedge clk);
            if (cyc >= 12 && load_valid && !m_pend && load_data == 16'h0050) second_done = 1'b1;
            model_step(cyc);
            #1;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
